mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 53 +++++
 rtl/alu_decoder.sv | 29 ++
 rtl/mc_controller.sv | 200 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, datapath mux selects,
// opcodes, ALU operation classes and the branch condition helper.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Taken decision from the subtract result flags; unsupported funct3 never branches.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic neg);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return neg;
      3'b101:  return !neg;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode: fixed add/sub for address and compare states, funct-based otherwise.
module alu_decoder
  import mc_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = 3'b000;
    if (alu_op == ALUOP_SUB) begin
      alu_control = 3'b001;
    end else if (alu_op == ALUOP_FUNCT) begin
      case (funct3)
        // sub only for R-type; addi with imm[10] set is still an add
        3'b000:  alu_control = (op5 && funct7b5) ? 3'b001 : 3'b000;
        3'b010:  alu_control = 3'b101;
        3'b100:  alu_control = 3'b100;
        3'b110:  alu_control = 3'b011;
        3'b111:  alu_control = 3'b010;
        default: alu_control = 3'b000;
      endcase
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM. Define MC_PERF_CNT_EN to add the cycle and
// retired-instruction counters (cycle_cnt, instret_cnt).
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7bit5,
  input  logic       Zero,
  input  logic       ALUbit31,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  state_t     state;
  aluop_t     alu_op;
  logic [2:0] alu_ctrl;

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  // State register; instr_done and illegal are set on the transition that earns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      case (state)
        S_FETCH:   if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            default: begin
              state   <= S_TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:  state <= (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD: if (mem_ready) state <= S_MEMWB;
        S_MEMWRITE: begin
          if (mem_ready) begin
            state      <= S_FETCH;
            instr_done <= 1'b1;
          end
        end
        S_MEMWB, S_ALUWB, S_BRANCH: begin
          state      <= S_FETCH;
          instr_done <= 1'b1;
        end
        S_EXECR, S_EXECI: state <= S_ALUWB;
        S_JAL:     state <= S_ALUWB;
        S_JALR:    state <= S_JAL;
        S_TRAP:    state <= S_TRAP;
        default: begin
          state   <= S_TRAP;
          illegal <= 1'b1;
        end
      endcase
    end
  end

  // Moore output decode; only the FETCH strobes look at mem_ready. Reset blanks everything.
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = IMM_I;
    alu_op    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        PCWrite = branch_taken(funct3, Zero, ALUbit31);
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        ImmSrc  = IMM_J;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      default: ;
    endcase
    if (reset) begin
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      ImmSrc    = 2'b00;
    end
  end

  alu_decoder u_alu_decoder (
    .op5         (opcode[5]),
    .funct3      (funct3),
    .funct7b5    (funct7bit5),
    .alu_op      (alu_op),
    .alu_control (alu_ctrl)
  );

  assign ALUControl = reset ? 3'b000 : alu_ctrl;

`ifdef MC_PERF_CNT_EN
  // Free-running counters, wrapping naturally at CNT_W bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction vector table with a
// scoreboard, plus stall, trap and mid-instruction reset sequences.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7bit5, Zero, ALUbit31, mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_done, illegal;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
  int          mon_ret;
`endif

  int total = 0;
  int bad   = 0;

  mc_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7bit5(funct7bit5), .Zero(Zero), .ALUbit31(ALUbit31),
    .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .instr_done(instr_done), .illegal(illegal)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

`ifdef MC_PERF_CNT_EN
  always @(negedge clk or posedge reset) begin
    if (reset) mon_ret <= 0;
    else if (instr_done) mon_ret <= mon_ret + 1;
  end
`endif

  // Per-cycle masks: bit i is cycle i of the instruction (bit 0 = FETCH).
  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, n;
    int         cycles;
    logic [7:0] rw, pc, mw, mreq;
    logic [2:0] alu3;
    logic [7:0] mux3;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input string name, input logic [6:0] op,
                              input logic [2:0] f3, input logic f7, input logic z,
                              input logic n, input int cycles, input logic [7:0] rw,
                              input logic [7:0] pc, input logic [7:0] mw,
                              input logic [7:0] mreq, input logic [2:0] alu3,
                              input logic [7:0] mux3);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.n = n;
    v.cycles = cycles; v.rw = rw; v.pc = pc; v.mw = mw; v.mreq = mreq;
    v.alu3 = alu3; v.mux3 = mux3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] all_outs();
    return {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
            ResultSrc, ImmSrc, ALUControl, instr_done, illegal};
  endfunction

  // Drive one instruction from its FETCH slot and observe until the retire pulse.
  task automatic run_vec(input vec_t v);
    vec_t       e;
    int         cyc;
    logic       done;
    logic [2:0] idx, a3;
    logic [7:0] rw, pc, mw, mrq, m1, m3;
    opcode = v.op; funct3 = v.f3; funct7bit5 = v.f7; Zero = v.z; ALUbit31 = v.n;
    mem_ready = 1'b1;
    exp_q.push_back(v);
    cyc = 0; done = 1'b0;
    rw = '0; pc = '0; mw = '0; mrq = '0; m1 = '0; m3 = '0; a3 = '0;
    while (!done && cyc < 12) begin
      #1;
      if (cyc > 0 && instr_done) begin
        done = 1'b1;
      end else begin
        if (cyc < 8) begin
          idx = cyc[2:0];
          rw[idx] = RegWrite; pc[idx] = PCWrite; mw[idx] = MemWrite; mrq[idx] = mem_req;
        end
        if (cyc == 1) m1 = {ALUSrcA, ALUSrcB, ImmSrc, ResultSrc};
        if (cyc == 2) begin
          m3 = {ALUSrcA, ALUSrcB, ImmSrc, ResultSrc};
          a3 = ALUControl;
        end
        cyc++;
        @(negedge clk);
      end
    end
    e = exp_q.pop_front();
    if (!done) begin
      total++; bad++;
      $display("FAIL %s.timeout: got no instr_done want instr_done within 12 cycles", e.name);
    end else begin
      check({e.name, ".cycles"}, 32'(cyc), 32'(e.cycles));
      check({e.name, ".regwrite"}, 32'(rw), 32'(e.rw));
      check({e.name, ".pcwrite"}, 32'(pc), 32'(e.pc));
      check({e.name, ".memwrite"}, 32'(mw), 32'(e.mw));
      check({e.name, ".mem_req"}, 32'(mrq), 32'(e.mreq));
      check({e.name, ".decode_mux"}, 32'(m1), 32'h58);
      check({e.name, ".c2_mux"}, 32'(m3), 32'(e.mux3));
      check({e.name, ".c2_alu"}, 32'(a3), 32'(e.alu3));
      check({e.name, ".illegal"}, 32'(illegal), 32'h0);
    end
  endtask

  initial begin
    int   mw_cnt, busy_cnt, cyc, ill_cnt, strobe_bad, done_seen;
    logic done, found;

    //            name     op          f3     f7 z  n  cyc rw     pc     mw     mreq   alu     mux3
    vecs.push_back(mk("lw",   7'b0000011, 3'b010, 0, 0, 0, 5, 8'h10, 8'h01, 8'h00, 8'h09, 3'b000, 8'h90));
    vecs.push_back(mk("sw",   7'b0100011, 3'b010, 0, 0, 0, 4, 8'h00, 8'h01, 8'h08, 8'h09, 3'b000, 8'h94));
    vecs.push_back(mk("add",  7'b0110011, 3'b000, 0, 0, 0, 4, 8'h08, 8'h01, 8'h00, 8'h01, 3'b000, 8'h80));
    vecs.push_back(mk("sub",  7'b0110011, 3'b000, 1, 0, 0, 4, 8'h08, 8'h01, 8'h00, 8'h01, 3'b001, 8'h80));
    vecs.push_back(mk("and",  7'b0110011, 3'b111, 0, 0, 0, 4, 8'h08, 8'h01, 8'h00, 8'h01, 3'b010, 8'h80));
    vecs.push_back(mk("or",   7'b0110011, 3'b110, 0, 0, 0, 4, 8'h08, 8'h01, 8'h00, 8'h01, 3'b011, 8'h80));
    vecs.push_back(mk("slt",  7'b0110011, 3'b010, 0, 0, 0, 4, 8'h08, 8'h01, 8'h00, 8'h01, 3'b101, 8'h80));
    vecs.push_back(mk("addi", 7'b0010011, 3'b000, 1, 0, 0, 4, 8'h08, 8'h01, 8'h00, 8'h01, 3'b000, 8'h90));
    vecs.push_back(mk("beq_t",7'b1100011, 3'b000, 0, 1, 0, 3, 8'h00, 8'h05, 8'h00, 8'h01, 3'b001, 8'h80));
    vecs.push_back(mk("beq_n",7'b1100011, 3'b000, 0, 0, 0, 3, 8'h00, 8'h01, 8'h00, 8'h01, 3'b001, 8'h80));
    vecs.push_back(mk("bne_n",7'b1100011, 3'b001, 0, 1, 0, 3, 8'h00, 8'h01, 8'h00, 8'h01, 3'b001, 8'h80));
    vecs.push_back(mk("bne_t",7'b1100011, 3'b001, 0, 0, 0, 3, 8'h00, 8'h05, 8'h00, 8'h01, 3'b001, 8'h80));
    vecs.push_back(mk("blt_t",7'b1100011, 3'b100, 0, 0, 1, 3, 8'h00, 8'h05, 8'h00, 8'h01, 3'b001, 8'h80));
    vecs.push_back(mk("bge_n",7'b1100011, 3'b101, 0, 0, 1, 3, 8'h00, 8'h01, 8'h00, 8'h01, 3'b001, 8'h80));
    vecs.push_back(mk("br010",7'b1100011, 3'b010, 0, 1, 1, 3, 8'h00, 8'h01, 8'h00, 8'h01, 3'b001, 8'h80));
    vecs.push_back(mk("jal",  7'b1101111, 3'b000, 0, 0, 0, 4, 8'h08, 8'h05, 8'h00, 8'h01, 3'b000, 8'h6C));
    vecs.push_back(mk("jalr", 7'b1100111, 3'b000, 0, 0, 0, 5, 8'h10, 8'h09, 8'h00, 8'h01, 3'b000, 8'h90));

    // Reset: everything low even with mem_ready high in FETCH.
    reset = 1'b1; opcode = '0; funct3 = '0; funct7bit5 = 1'b0;
    Zero = 1'b0; ALUbit31 = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset.outs", 32'(all_outs()), 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("fetch.wait0", 32'({mem_req, AdrSrc, IRWrite, PCWrite, instr_done, illegal}), 32'h20);
    @(negedge clk);
    #1;
    check("fetch.wait1", 32'({mem_req, AdrSrc, IRWrite, PCWrite, instr_done, illegal}), 32'h20);
    mem_ready = 1'b1;
    #1;
    check("fetch.ready", 32'({IRWrite, PCWrite, ALUSrcA, ALUSrcB, ResultSrc}), 32'hCA);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Store held off by three not-ready cycles in MEMWRITE.
    opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    mw_cnt = 0; busy_cnt = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 15) begin
      #1;
      if (cyc > 0 && instr_done) begin
        done = 1'b1;
      end else begin
        if (MemWrite) begin
          mw_cnt++;
          mem_ready = (mw_cnt >= 4);
        end
        if (mem_req && AdrSrc && MemWrite) busy_cnt++;
        cyc++;
        @(negedge clk);
      end
    end
    mem_ready = 1'b1;
    check("sw_stall.done", 32'(done), 32'h1);
    check("sw_stall.memwrite_cycles", 32'(mw_cnt), 32'd4);
    check("sw_stall.req_cycles", 32'(busy_cnt), 32'd4);
    check("sw_stall.cycles", 32'(cyc), 32'd7);

    // Reset during a MEMREAD wait abandons the load.
    opcode = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1; found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      #1;
      if (mem_req && AdrSrc && !MemWrite) begin
        found = 1'b1;
        mem_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check("mr_rst.found", 32'(found), 32'h1);
    @(negedge clk);
    #1;
    check("mr_rst.waiting", 32'({mem_req, AdrSrc, RegWrite}), 32'h6);
    reset = 1'b1;
    #1;
    check("mr_rst.outs", 32'(all_outs()), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_rst.fetch", 32'({mem_req, AdrSrc, RegWrite, instr_done}), 32'h8);
    repeat (3) @(negedge clk);
    check("mr_rst.no_retire", 32'({mem_req, AdrSrc, instr_done}), 32'h4);
`ifdef MC_PERF_CNT_EN
    check("mr_rst.cycle_cnt", cycle_cnt, 32'd3);
    check("mr_rst.instret_cnt", instret_cnt, 32'd0);
`endif
    #1;
    run_vec(vecs[0]);

    // Unknown opcode (lui) locks into TRAP until reset.
    opcode = 7'b0110111; mem_ready = 1'b1;
    ill_cnt = 0; strobe_bad = 0; done_seen = 0;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2 && {mem_req, MemWrite, IRWrite, PCWrite, RegWrite} != 5'b0) strobe_bad++;
      if (illegal) ill_cnt++;
      if (c > 0 && instr_done) done_seen++;
      @(negedge clk);
      #1;
    end
    check("trap.illegal_cycles", 32'(ill_cnt), 32'd6);
    check("trap.strobes", 32'(strobe_bad), 32'd0);
    check("trap.no_retire", 32'(done_seen), 32'd0);
`ifdef MC_PERF_CNT_EN
    check("trap.instret_cnt", instret_cnt, 32'(mon_ret));
`endif
    reset = 1'b1;
    #1;
    check("trap_rst.outs", 32'(all_outs()), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    opcode = 7'b0110011;
    #1;
    check("trap_rst.fetch", 32'({mem_req, AdrSrc, illegal, instr_done}), 32'h8);
    run_vec(vecs[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want end within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
